// File: rtl/led_7seg_mux.sv
// rtl/led_7seg_mux.sv - multiplexed common-anode seven-segment driver with frame-synchronous double buffering
// Optional build macro: LED_7SEG_LZS_EN (leading-zero suppression on the active buffer).
module led_7seg_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [NUM_DIGITS-1:0]     blank,
  output logic [NUM_DIGITS-1:0]     enable,
  output logic [6:0]                segs,
  output logic                      decimal,
  output logic                      frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, act_data_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
  logic [NUM_DIGITS-1:0]   pend_blank_q, act_blank_q;
  logic [NUM_DIGITS-1:0]   enable_d;
  logic [6:0]              segs_d;
  logic                    decimal_d;
  logic                    tick, commit;
  logic [NUM_DIGITS-1:0]   eff_blank;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'b1000000;
      4'h1: hex_decode = 7'b1111001;
      4'h2: hex_decode = 7'b0100100;
      4'h3: hex_decode = 7'b0110000;
      4'h4: hex_decode = 7'b0011001;
      4'h5: hex_decode = 7'b0010010;
      4'h6: hex_decode = 7'b0000010;
      4'h7: hex_decode = 7'b1111000;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0010000;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b0000011;
      4'hC: hex_decode = 7'b1000110;
      4'hD: hex_decode = 7'b0100001;
      4'hE: hex_decode = 7'b0000110;
      default: hex_decode = 7'b0001110;
    endcase
  endfunction

  // Slot prescaler and digit index; a tick on the last digit closes the frame.
  always_comb begin
    tick   = (cnt_q == CW'(REFRESH_DIV - 1));
    commit = tick && (idx_q == IW'(NUM_DIGITS - 1));
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (tick) idx_d = commit ? '0 : idx_q + 1'b1;
  end

`ifdef LED_7SEG_LZS_EN
  // Suppress a zero digit while every digit above it is zero or blanked; digit 0 always shows.
  always_comb begin
    logic hi_clear;
    logic zero;
    eff_blank = act_blank_q;
    hi_clear  = 1'b1;
    zero      = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero = (act_data_q[4*i +: 4] == 4'h0) && !act_dp_q[i];
      if (zero && hi_clear) eff_blank[i] = 1'b1;
      hi_clear = hi_clear && (zero || act_blank_q[i]);
    end
  end
`else
  // Only the explicit blank request hides a digit.
  always_comb begin
    eff_blank = act_blank_q;
  end
`endif

  // Next display outputs from the current slot position and active buffer.
  always_comb begin
    enable_d  = '1;
    segs_d    = 7'b1111111;
    decimal_d = 1'b1;
    if (!((cnt_q < CW'(BLANK_CYCLES)) || eff_blank[idx_q])) begin
      enable_d  = ~(NUM_DIGITS'(1) << idx_q);
      segs_d    = hex_decode(act_data_q[{idx_q, 2'b00} +: 4]);
      decimal_d = ~act_dp_q[idx_q];
    end
  end

  // State, double buffers and registered pins; commit sees pending before any same-edge load.
  always_ff @(posedge clock) begin
    if (!clear) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      enable       <= '1;
      segs         <= 7'b1111111;
      decimal      <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      enable     <= enable_d;
      segs       <= segs_d;
      decimal    <= decimal_d;
      frame_done <= commit;
      if (commit) begin
        act_data_q  <= pend_data_q;
        act_dp_q    <= pend_dp_q;
        act_blank_q <= pend_blank_q;
      end
      if (load) begin
        pend_data_q  <= data;
        pend_dp_q    <= dp;
        pend_blank_q <= blank;
      end
    end
  end

endmodule

// File: tb/tb_led_7seg_mux.sv
// tb/tb_led_7seg_mux.sv - directed and random checks of led_7seg_mux against a cycle-count reference model
module tb_led_7seg_mux;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BC = 1;
  localparam int FRAME = ND * RD;

  logic          clock = 1'b0;
  logic          clear, load;
  logic [15:0]   data;
  logic [3:0]    dp, blank;
  logic [3:0]    enable;
  logic [6:0]    segs;
  logic          decimal, frame_done;

  int total = 0;
  int bad   = 0;

  // Reference state: cycles since reset release plus the two buffers.
  int          cyc;
  logic [15:0] p_data, a_data;
  logic [3:0]  p_dp, a_dp, p_bl, a_bl;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  led_7seg_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clock(clock), .clear(clear), .load(load), .data(data), .dp(dp), .blank(blank),
    .enable(enable), .segs(segs), .decimal(decimal), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic hidden(input int i);
    logic hide;
    int   top_sig;
    hide = a_bl[i];
`ifdef LED_7SEG_LZS_EN
    top_sig = 0;
    for (int j = 0; j < ND; j++)
      if ((a_data[4*j +: 4] != 4'h0 || a_dp[j]) && !a_bl[j]) top_sig = j;
    if (i > 0 && i > top_sig && a_data[4*i +: 4] == 4'h0 && !a_dp[i]) hide = 1'b1;
`else
    top_sig = 0;
`endif
    return hide || (top_sig < 0);
  endfunction

  task automatic step();
    logic [3:0] e_en;
    logic [6:0] e_sg;
    logic       e_dp, e_fd;
    int c, i;
    c = cyc % RD;
    i = (cyc / RD) % ND;
    e_en = 4'hF; e_sg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    if (clear) begin
      if (c >= BC && !hidden(i)) begin
        e_en[i] = 1'b0;
        e_sg    = hex_tab[a_data[4*i +: 4]];
        e_dp    = ~a_dp[i];
      end
      e_fd = (c == RD - 1) && (i == ND - 1);
      if (e_fd) begin a_data = p_data; a_dp = p_dp; a_bl = p_bl; end
      if (load) begin p_data = data; p_dp = dp; p_bl = blank; end
      cyc++;
    end else begin
      cyc = 0;
      p_data = '0; a_data = '0; p_dp = '0; a_dp = '0; p_bl = '0; a_bl = '0;
    end
    @(posedge clock);
    #1;
    check("enable", 32'(enable), 32'(e_en));
    check("segs", 32'(segs), 32'(e_sg));
    check("decimal", 32'(decimal), 32'(e_dp));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("onehot_low", 32'($countones(~enable) <= 1), 32'(1));
  endtask

  task automatic run_to(input int phase);
    for (int k = 0; k < FRAME && (cyc % FRAME) != phase; k++) step();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    data = d; dp = p; blank = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    clear = 1'b0; load = 1'b0; data = '0; dp = '0; blank = '0;
    cyc = 0;
    p_data = '0; a_data = '0; p_dp = '0; a_dp = '0; p_bl = '0; a_bl = '0;

    repeat (3) step();
    clear = 1'b1;
    repeat (2 * FRAME) step();

    run_to(6);
    do_load(16'h8A10, 4'b0100, 4'b0000);
    repeat (2 * FRAME) step();

    run_to(5);
    do_load(16'h1234, 4'b0000, 4'b0000);
    run_to(FRAME - 1);
    do_load(16'hFFFF, 4'b0000, 4'b0000);
    repeat (3 * FRAME) step();

    run_to(3);
    do_load(16'h5555, 4'b0000, 4'b0010);
    repeat (2 * FRAME) step();

    run_to(10);
    clear = 1'b0;
    step();
    clear = 1'b1;
    repeat (FRAME + 4) step();

    do_load(16'h0070, 4'b0000, 4'b0000);
    repeat (2 * FRAME) step();
    do_load(16'h0000, 4'b0000, 4'b0000);
    repeat (2 * FRAME) step();
    do_load(16'h0300, 4'b0000, 4'b0100);
    repeat (2 * FRAME) step();

    for (int n = 0; n < 800; n++) begin
      load  = ($urandom_range(0, 7) == 0);
      data  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data[15:8] = 8'h00;
      dp    = 4'($urandom);
      blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      clear = ($urandom_range(0, 199) != 0);
      step();
    end
    load = 1'b0; clear = 1'b1;
    repeat (FRAME) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
